// File: rtl/ahb_mem_responder.sv
// AHB-Lite slave backed by a word-addressed register memory. It adds WAIT_STATES wait
// cycles to each OKAY beat, checks burst addresses and gives two-cycle ERROR responses.
module ahb_mem_responder #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [31:0] addr,
  input  logic        hwrite,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hburst,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_WRAP4  = 3'b010;
  localparam logic [2:0] BURST_INCR4  = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  state_e                state_q, state_d;
  logic [31:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  write_q;
  logic [2:0]            wait_cnt_q;
  logic [31:0]           hrdata_q;
  logic                  burst_active_q;
  logic [2:0]            burst_q;
  logic [1:0]            beat_cnt_q;
  logic [31:0]           exp_addr_q;

  logic active, bounded, base_err, seq_err, beat_err, accept_ok, accept_err;

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] burst);
    if (burst == BURST_WRAP4) return {a[31:4], a[3:0] + 4'd4};
    return a + 32'd4;
  endfunction

  // Address-phase decode; only meaningful on edges where hready is high.
  always_comb begin
    active     = hready && hsel && htrans[1];
    bounded    = (burst_q == BURST_WRAP4) || (burst_q == BURST_INCR4);
    base_err   = (hsize != 3'b010) || (addr[1:0] != 2'b00) ||
                 ((addr >> (DEPTH_LOG2 + 2)) != 32'd0);
    seq_err    = (htrans == TRANS_SEQ) &&
                 (!burst_active_q || (addr != exp_addr_q) || (bounded && beat_cnt_q == 2'd3));
    beat_err   = base_err || seq_err;
    accept_ok  = active && !beat_err;
    accept_err = active && beat_err;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept_err)     state_d = ST_ERR1;
        else if (accept_ok) state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;
        else                state_d = ST_IDLE;
      end
      ST_WAIT: if (wait_cnt_q == 3'd0) state_d = ST_DATA;
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = hrdata_q;
    case (state_q)
      ST_WAIT: hready = 1'b0;
      ST_ERR1: begin
        hready = 1'b0;
        hresp  = 1'b1;
      end
      ST_ERR2: hresp = 1'b1;
      ST_DATA: if (!write_q) hrdata = mem_q[idx_q];
      default: ;
    endcase
  end

  // NOTE: the memory is reset on purpose, each word to its own byte address; this
  // costs a reset path on every storage flop and rules out a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'(i) << 2;
    end else if (state_q == ST_DATA && write_q) begin
      mem_q[idx_q] <= hwdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q          <= '0;
      write_q        <= 1'b0;
      wait_cnt_q     <= 3'd0;
      hrdata_q       <= 32'd0;
      burst_active_q <= 1'b0;
      burst_q        <= BURST_SINGLE;
      beat_cnt_q     <= 2'd0;
      exp_addr_q     <= 32'd0;
    end else begin
      hrdata_q <= hrdata;
      if (state_q == ST_WAIT) wait_cnt_q <= wait_cnt_q - 3'd1;
      if (accept_ok) begin
        idx_q      <= addr[DEPTH_LOG2+1:2];
        write_q    <= hwrite;
        wait_cnt_q <= WAIT_LOAD;
      end
      // A failed SEQ leaves burst tracking alone; a failed NONSEQ kills the burst.
      if (accept_ok && htrans == TRANS_NONSEQ) begin
        burst_active_q <= (hburst != BURST_SINGLE);
        burst_q        <= hburst;
        beat_cnt_q     <= 2'd0;
        exp_addr_q     <= next_addr(addr, hburst);
      end else if (accept_ok) begin
        beat_cnt_q <= beat_cnt_q + 2'd1;
        exp_addr_q <= next_addr(addr, burst_q);
      end else if (accept_err && htrans == TRANS_NONSEQ) begin
        burst_active_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_mem_responder.sv
// Self-checking bench for ahb_mem_responder: directed scenarios plus random bursts,
// scored against a transaction-level model of the memory and the burst rules.
module tb_ahb_mem_responder;

  localparam int DEPTH_LOG2  = 6;
  localparam int WAIT_STATES = 1;
  localparam int DEPTH       = 1 << DEPTH_LOG2;

  localparam bit [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10, T_SEQ = 2'b11;
  localparam bit [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_WRAP4 = 3'd2, B_INCR4 = 3'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [31:0] addr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  always #5 clk = ~clk;

  ahb_mem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .WAIT_STATES(WAIT_STATES)) dut (
    .clk    (clk),
    .rst    (rst),
    .hsel   (hsel),
    .addr   (addr),
    .hwrite (hwrite),
    .htrans (htrans),
    .hburst (hburst),
    .hsize  (hsize),
    .hwdata (hwdata),
    .hrdata (hrdata),
    .hready (hready),
    .hresp  (hresp)
  );

  typedef struct {
    bit        sel;
    bit [1:0]  trans;
    bit [2:0]  burst;
    bit [2:0]  size;
    bit [31:0] a;
    bit        wr;
    bit [31:0] wdata;
  } beat_t;

  beat_t       q[$];
  logic [31:0] rd_log[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_last_rd;
  bit          m_in_burst;
  bit [2:0]    m_type;
  bit [31:0]   m_prev;
  int          m_nbeats;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(input bit [1:0] trans, input bit [2:0] burst, input bit [31:0] a,
                               input bit wr, input bit [31:0] wdata);
    beat_t b;
    b.sel = 1'b1; b.trans = trans; b.burst = burst; b.size = 3'd2;
    b.a = a; b.wr = wr; b.wdata = wdata;
    return b;
  endfunction

  function automatic beat_t idle_beat();
    beat_t b;
    b.sel = 1'b0; b.trans = T_IDLE; b.burst = B_SINGLE; b.size = 3'd2;
    b.a = 32'd0; b.wr = 1'b0; b.wdata = 32'd0;
    return b;
  endfunction

  task automatic drive(input beat_t b);
    hsel = b.sel; htrans = b.trans; hburst = b.burst; hsize = b.size;
    addr = b.a; hwrite = b.wr;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'(i * 4);
    m_last_rd  = 32'd0;
    m_in_burst = 1'b0;
    m_type     = B_SINGLE;
    m_prev     = 32'd0;
    m_nbeats   = 0;
  endtask

  // Returns 1 when the beat must receive an ERROR response; updates burst tracking.
  function automatic bit model_accept(input beat_t b);
    bit        base, err;
    bit [31:0] expa;
    if (!(b.sel && (b.trans == T_NONSEQ || b.trans == T_SEQ))) return 1'b0;
    base = (b.size != 3'd2) || (b.a % 4 != 0) || (b.a >= 32'(4 * DEPTH));
    if (b.trans == T_NONSEQ) begin
      err = base;
      if (!err) begin
        m_in_burst = (b.burst != B_SINGLE);
        m_type = b.burst; m_prev = b.a; m_nbeats = 1;
      end else begin
        m_in_burst = 1'b0;
      end
    end else begin
      if (m_type == B_WRAP4) expa = (m_prev & ~32'hF) | ((m_prev + 32'd4) & 32'hF);
      else                   expa = m_prev + 32'd4;
      err = base || !m_in_burst || (b.a != expa) ||
            ((m_type == B_WRAP4 || m_type == B_INCR4) && m_nbeats >= 4);
      if (!err) begin
        m_prev = b.a;
        m_nbeats++;
      end
    end
    return err;
  endfunction

  // Plays the queued beats as a pipelined master and scores every completed data phase.
  task automatic run_seq();
    beat_t       cur, dp;
    bit          have_cur, dp_valid, dp_err, dp_act, accepted, done;
    int          waits, exp_waits, budget;
    logic [31:0] exp_rd;
    budget   = 20 * q.size() + 50;
    dp_valid = 1'b0; dp_err = 1'b0; dp_act = 1'b0; done = 1'b0; waits = 0;
    dp       = idle_beat();
    @(posedge clk); #1;
    have_cur = (q.size() > 0);
    if (have_cur) cur = q.pop_front();
    else          cur = idle_beat();
    drive(cur);
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      @(negedge clk);
      accepted = 1'b0;
      if (!hready) begin
        if (dp_valid) begin
          waits++;
          check("hresp_in_wait", 32'(hresp), 32'(dp_err));
        end else begin
          check("hready_low_idle", 32'(hready), 32'd1);
        end
      end else begin
        if (dp_valid) begin
          exp_waits = !dp_act ? 0 : (dp_err ? 1 : WAIT_STATES);
          check("wait_cycles", 32'(waits), 32'(exp_waits));
          check("hresp", 32'(hresp), 32'(dp_err));
          if (dp_act && !dp_err && !dp.wr) exp_rd = m_mem[dp.a[DEPTH_LOG2+1:2]];
          else                             exp_rd = m_last_rd;
          check("hrdata", hrdata, exp_rd);
          if (dp_act && !dp_err) begin
            if (dp.wr) m_mem[dp.a[DEPTH_LOG2+1:2]] = dp.wdata;
            else begin
              m_last_rd = exp_rd;
              rd_log.push_back(hrdata);
            end
          end
        end
        dp_valid = have_cur;
        if (have_cur) begin
          dp     = cur;
          dp_act = cur.sel && cur.trans[1];
          dp_err = model_accept(cur);
          waits  = 0;
        end else begin
          done = 1'b1;
        end
        accepted = 1'b1;
      end
      if (!done) begin
        @(posedge clk); #1;
        if (accepted) begin
          hwdata = dp.wdata;
          if (q.size() > 0) begin
            cur = q.pop_front();
            have_cur = 1'b1;
          end else begin
            cur = idle_beat();
            have_cur = 1'b0;
          end
          drive(cur);
        end
      end
    end
    if (!done) begin
      check("seq_timeout", 32'd0, 32'd1);
      q.delete();
    end
  endtask

  task automatic gen_random(input int n_bursts);
    bit [2:0]  bt;
    bit [31:0] a;
    beat_t     b;
    int        len;
    for (int n = 0; n < n_bursts; n++) begin
      case ($urandom_range(0, 3))
        0:       bt = B_SINGLE;
        1:       bt = B_INCR;
        2:       bt = B_WRAP4;
        default: bt = B_INCR4;
      endcase
      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      if ($urandom_range(0, 15) == 0) a = a | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) a = a + 32'(4 * DEPTH);
      if (bt == B_SINGLE)    len = 1;
      else if (bt == B_INCR) len = $urandom_range(1, 6);
      else                   len = $urandom_range(4, 5);
      for (int k = 0; k < len; k++) begin
        b = mk((k == 0 && $urandom_range(0, 15) != 0) ? T_NONSEQ : T_SEQ, bt, a,
               1'($urandom_range(0, 1)), $urandom);
        if ($urandom_range(0, 19) == 0) b.size = 3'($urandom_range(0, 1));
        q.push_back(b);
        if ($urandom_range(0, 5) == 0) q.push_back(mk(T_BUSY, bt, a, 1'b0, 32'd0));
        if (bt == B_WRAP4) a = (a & ~32'hF) | ((a + 32'd4) & 32'hF);
        else               a = a + 32'd4;
        if ($urandom_range(0, 11) == 0) a = a + 32'd4;
      end
      if ($urandom_range(0, 3) == 0) begin
        b = idle_beat();
        b.sel = 1'($urandom_range(0, 1));
        b.trans = 2'($urandom_range(0, 3));
        b.sel = b.sel && !b.trans[1];
        q.push_back(b);
      end
    end
  endtask

  logic [31:0] wrap_exp [4];

  initial begin
    wrap_exp[0] = 32'h38; wrap_exp[1] = 32'h3C; wrap_exp[2] = 32'h30; wrap_exp[3] = 32'h34;
    rst = 1'b1; hwdata = 32'd0;
    drive(idle_beat());
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_hready", 32'(hready), 32'd1);
    check("reset_hresp", 32'(hresp), 32'd0);
    check("reset_hrdata", hrdata, 32'd0);

    // Single read with one wait state
    q.push_back(mk(T_NONSEQ, B_SINGLE, 32'h10, 1'b0, 32'd0));
    run_seq();
    check("single_read_count", 32'(rd_log.size()), 32'd1);
    if (rd_log.size() > 0) check("single_read_data", rd_log[rd_log.size()-1], 32'h10);

    // WRAP4 read wrapping at the 16-byte boundary
    rd_log.delete();
    q.push_back(mk(T_NONSEQ, B_WRAP4, 32'h38, 1'b0, 32'd0));
    q.push_back(mk(T_SEQ,    B_WRAP4, 32'h3C, 1'b0, 32'd0));
    q.push_back(mk(T_SEQ,    B_WRAP4, 32'h30, 1'b0, 32'd0));
    q.push_back(mk(T_SEQ,    B_WRAP4, 32'h34, 1'b0, 32'd0));
    run_seq();
    check("wrap4_count", 32'(rd_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < rd_log.size(); i++) check("wrap4_data", rd_log[i], wrap_exp[i]);

    // Write then immediate read of the same word
    rd_log.delete();
    q.push_back(mk(T_NONSEQ, B_SINGLE, 32'h4, 1'b1, 32'hDEAD_BEEF));
    q.push_back(mk(T_NONSEQ, B_SINGLE, 32'h4, 1'b0, 32'd0));
    run_seq();
    check("raw_count", 32'(rd_log.size()), 32'd1);
    if (rd_log.size() > 0) check("raw_data", rd_log[0], 32'hDEAD_BEEF);

    // Misaligned / out-of-range beats must not touch memory
    rd_log.delete();
    q.push_back(mk(T_NONSEQ, B_SINGLE, 32'h102, 1'b0, 32'd0));
    q.push_back(mk(T_NONSEQ, B_SINGLE, 32'h0A,  1'b1, 32'hBAD0_BAD0));
    q.push_back(mk(T_NONSEQ, B_SINGLE, 32'h08,  1'b0, 32'd0));
    run_seq();
    check("misalign_count", 32'(rd_log.size()), 32'd1);
    if (rd_log.size() > 0) check("misalign_mem", rd_log[0], 32'h08);

    // INCR4: bad SEQ address, BUSY in the middle, then a fifth beat
    rd_log.delete();
    q.push_back(mk(T_NONSEQ, B_INCR4, 32'h00, 1'b0, 32'd0));
    q.push_back(mk(T_SEQ,    B_INCR4, 32'h08, 1'b0, 32'd0));
    q.push_back(mk(T_BUSY,   B_INCR4, 32'h04, 1'b0, 32'd0));
    q.push_back(mk(T_SEQ,    B_INCR4, 32'h04, 1'b0, 32'd0));
    q.push_back(mk(T_SEQ,    B_INCR4, 32'h08, 1'b0, 32'd0));
    q.push_back(mk(T_SEQ,    B_INCR4, 32'h0C, 1'b0, 32'd0));
    q.push_back(mk(T_SEQ,    B_INCR4, 32'h10, 1'b0, 32'd0));
    run_seq();
    check("incr4_ok_reads", 32'(rd_log.size()), 32'd4);

    // Random traffic
    gen_random(200);
    run_seq();

    // Reset during the wait state of a write
    @(posedge clk); #1;
    drive(mk(T_NONSEQ, B_SINGLE, 32'h20, 1'b1, 32'h1234_5678));
    @(posedge clk); #1;
    check("wait_before_reset", 32'(hready), 32'd0);
    hwdata = 32'h1234_5678;
    rst = 1'b1;
    drive(idle_beat());
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_hready", 32'(hready), 32'd1);
    check("post_reset_hresp", 32'(hresp), 32'd0);
    model_reset();
    rd_log.delete();
    q.push_back(mk(T_NONSEQ, B_SINGLE, 32'h20, 1'b0, 32'd0));
    run_seq();
    check("reset_abort_count", 32'(rd_log.size()), 32'd1);
    if (rd_log.size() > 0) check("reset_abort_data", rd_log[0], 32'h20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
